// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Accepts one word read or write in IDLE, waits LATENCY cycles,
// performs the access, then pulses done for one cycle.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic              req_valid;
    logic              req_invalid;

    logic [31:0]       mem [2**ADDR_W];

    // Address bits above the word index only alias the same storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign req_valid   = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
    assign req_invalid = (mem_read | mem_write) && !req_valid;

    // Next-state, latched request and registered output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_write_d = mem_write;
                    widx_d     = addr[ADDR_W+1:2];
                    wdata_d    = wdata;
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = WAIT;
                end else if (req_invalid) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (op_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[widx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            widx_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Storage write; reset drops a pending store and never clears contents.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[widx_q] <= wdata_q;
        end
    end

    assign busy  = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
    assign rdata = rdata_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a timeline model.
module tb_dmem_responder;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 2**ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    dmem_responder #(
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- timeline reference model ----------------
    // A request accepted at cycle t finishes its access on the edge ending
    // cycle t+LATENCY and reports done in cycle t+LATENCY+1.
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_pend = 1'b0;
    bit          m_pwrite;
    int          m_pidx;
    logic [31:0] m_pdata;
    int          m_done_at;
    bit          m_err = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          m_rknown = 1'b1;
    int          cyc = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit req, valid, exp_busy, exp_done;
                req      = mem_read | mem_write;
                valid    = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
                exp_busy = (!m_pend && valid) || (m_pend && cyc < m_done_at);
                exp_done = m_pend && (cyc == m_done_at);
                check("busy", 32'(busy), 32'(exp_busy));
                check("done", 32'(done), 32'(exp_done));
                check("err",  32'(err),  32'(m_err));
                if (m_rknown) check("rdata", rdata, m_rdata);

                if (rst) begin
                    m_pend   = 1'b0;
                    m_err    = 1'b0;
                    m_rdata  = '0;
                    m_rknown = 1'b1;
                end else begin
                    bit was_pend;
                    was_pend = m_pend;
                    m_err = !was_pend && req && !valid;
                    if (was_pend && cyc == m_done_at - 1) begin
                        if (m_pwrite) begin
                            m_mem[m_pidx]   = m_pdata;
                            m_known[m_pidx] = 1'b1;
                        end else begin
                            m_rdata  = m_mem[m_pidx];
                            m_rknown = m_known[m_pidx];
                        end
                    end
                    if (was_pend && cyc == m_done_at) m_pend = 1'b0;
                    if (!was_pend && valid) begin
                        m_pend    = 1'b1;
                        m_pwrite  = mem_write;
                        m_pidx    = int'(addr[ADDR_W+1:2]);
                        m_pdata   = wdata;
                        m_done_at = cyc + LATENCY + 1;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- directed helpers ----------------
    // Present a request for one cycle and observe 12 cycles from the accept cycle.
    task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output int busy_cycles, output int done_lat,
                      output logic [31:0] rd_val, output bit err_seen);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        busy_cycles = 0; done_lat = -1; rd_val = 'x; err_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done && done_lat < 0) begin
                done_lat = i;
                rd_val = rdata;
            end
            if (i == 1 && err) err_seen = 1'b1;
            @(posedge clk); #1;
            if (i == 0) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
    endtask

    initial begin
        int bc, dl, n_done, second_at;
        logic [31:0] rv;
        bit es;

        // 1. reset for two cycles
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        check("reset_err",   32'(err),  32'd0);
        check("reset_rdata", rdata,     32'd0);

        // 2. write then read back
        op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, bc, dl, rv, es);
        check("wr_busy_cycles", 32'(bc), 32'd4);
        check("wr_done_lat",    32'(dl), 32'd4);
        op(1'b1, 1'b0, 32'h10, 32'h0, bc, dl, rv, es);
        check("rd_done_lat", 32'(dl), 32'd4);
        check("rd_data",     rv,      32'hDEADBEEF);

        // 3. misaligned read
        op(1'b1, 1'b0, 32'h12, 32'h0, bc, dl, rv, es);
        check("misalign_err",  32'(es), 32'd1);
        check("misalign_busy", 32'(bc), 32'd0);
        check("misalign_done", 32'(dl), 32'hFFFFFFFF);
        @(negedge clk);
        check("misalign_rdata_held", rdata, 32'hDEADBEEF);

        // 4. both strobes high
        op(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, bc, dl, rv, es);
        op(1'b1, 1'b1, 32'h20, 32'h55555555, bc, dl, rv, es);
        check("both_err",  32'(es), 32'd1);
        check("both_done", 32'(dl), 32'hFFFFFFFF);
        op(1'b1, 1'b0, 32'h20, 32'h0, bc, dl, rv, es);
        check("both_readback", rv, 32'hAAAAAAAA);

        // 5. reset two cycles after accepting a write
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h20; wdata = 32'h11111111;
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_rdata", rdata,     32'd0);
        op(1'b1, 1'b0, 32'h20, 32'h0, bc, dl, rv, es);
        check("abort_readback", rv, 32'hAAAAAAAA);

        // 6. address wrap-around
        op(1'b0, 1'b1, 32'h400, 32'h00000005, bc, dl, rv, es);
        op(1'b1, 1'b0, 32'h000, 32'h0, bc, dl, rv, es);
        check("wrap_readback", rv, 32'h00000005);

        // back-to-back: read held high, second accept the cycle after done
        @(posedge clk); #1;
        mem_read = 1'b1; addr = 32'h10;
        n_done = 0; second_at = -1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 2) second_at = i;
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0;
        check("b2b_done_count", 32'(n_done),    32'd2);
        check("b2b_second_at",  32'(second_at), 32'd9);
        repeat (6) @(posedge clk);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 63) == 0);
            mem_read  = ($urandom_range(0, 2) == 0);
            mem_write = ($urandom_range(0, 2) == 0);
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            addr  = a;
            wdata = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
